fetch_sequencer: RTL

Control FSM that sequences instruction fetch for the 16-bit core. It owns the program counter and issues held request/acknowledge reads to instruction memory. It latches the returned word and hands it to decode with a valid/ready handshake, pulsing the instruction-register load strobe. Jump and taken-branch redirects squash wrong-path fetches.

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch control: owns the PC, runs req/ack reads to instruction
// memory, and hands each fetched word to decode with a valid/ready handshake.
module fetch_sequencer #(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [15:0]         imem_data_i,
  output logic [15:0]         inst_o,
  output logic                inst_valid_o,
  output logic                ir_load_o,
  input  logic                dec_ready_i,
  input  logic                jump_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic                halt_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                busy_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   addr_q;
  logic                  req_q;
  logic [15:0]           inst_q;
  logic                  valid_q;
  logic                  load_q;
  logic                  squash_q;
  logic                  redirect;

  assign redirect = jump_i | branch_taken_i;

  // Every transition into FETCH also launches a request at the new PC, so the
  // memory address only ever moves on the edge that starts a transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      req_q    <= 1'b0;
      inst_q   <= 16'h0000;
      valid_q  <= 1'b0;
      load_q   <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (redirect) begin
            pc_q    <= target_i;
            addr_q  <= target_i;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end else if (halt_i) begin
            state_q <= HALTED;
          end else begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end

        FETCH: begin
          if (imem_ack_i) begin
            if (squash_q || redirect) begin
              // Wrong-path word: drop it and reissue at the newest PC.
              squash_q <= 1'b0;
              req_q    <= 1'b1;
              if (redirect) begin
                pc_q   <= target_i;
                addr_q <= target_i;
              end else begin
                addr_q <= pc_q;
              end
            end else begin
              inst_q  <= imem_data_i;
              valid_q <= 1'b1;
              load_q  <= 1'b1;
              pc_q    <= pc_q + PC_WIDTH'(1);
              req_q   <= 1'b0;
              state_q <= HOLD;
            end
          end else if (redirect) begin
            pc_q     <= target_i;
            squash_q <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect) begin
            valid_q <= 1'b0;
            pc_q    <= target_i;
            addr_q  <= target_i;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end else if (dec_ready_i) begin
            valid_q <= 1'b0;
            if (halt_i) begin
              state_q <= HALTED;
            end else begin
              addr_q  <= pc_q;
              req_q   <= 1'b1;
              state_q <= FETCH;
            end
          end
        end

        HALTED: begin
          req_q <= 1'b0;
          if (redirect) begin
            pc_q    <= target_i;
            addr_q  <= target_i;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end else if (!halt_i) begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign ir_load_o    = load_q;
  assign pc_o         = pc_q;
  assign busy_o       = (state_q == FETCH);
  assign state_o      = state_q;

endmodule
